vga_sprite_engine: RTL and testbench
====================================

VGA_SPRITE_ENGINE -- requirements
Module: vga_sprite_engine

Interface
REQ-001 SHALL have parameter H_SYNC, default 96, meaning horizontal sync width in pixels.
REQ-002 SHALL have parameter H_BP, default 48, meaning horizontal back porch; H_ACT, default 640, active width; H_FP, default 16, front porch.
REQ-003 SHALL have parameter V_SYNC, default 2; V_BP, default 33; V_ACT, default 480; V_FP, default 10; all in lines.
REQ-004 SHALL have parameter N_SPR, default 4, meaning sprite channel count (1..16); COORD_W, default 11, meaning coordinate width.
REQ-005 SHALL have port clk, input, 1, meaning pixel clock.
REQ-006 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-007 SHALL have upd_valid in 1, upd_ready out 1, upd_id in max(1,$clog2(N_SPR)), meaning sprite-update handshake and target channel.
REQ-008 SHALL have upd_x, upd_y, upd_w, upd_h in COORD_W each, upd_en in 1, upd_rgb in 24, meaning sprite geometry, enable and colour.
REQ-009 SHALL have red, green, blue out 8 each; h_sync, v_sync out 1, active-low; blank_n out 1; sync_n out 1, tied 0; frame_start out 1, one-cycle pulse.

Function
REQ-010 SHALL run h_ctr 0..H_TOTAL-1 (H_TOTAL = sum of H params), wrapping to 0; v_ctr SHALL advance only on h_ctr wrap, range 0..V_TOTAL-1.
REQ-011 SHALL order each line/frame as sync, back porch, active, front porch; raw h_sync low when h_ctr < H_SYNC, raw v_sync low when v_ctr < V_SYNC.
REQ-012 SHALL define active when h_ctr in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT) and v_ctr in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT); pixel x,y = counters minus those offsets.
REQ-013 SHALL hold a shadow and an active register set per channel; an accepted update (upd_valid & upd_ready) writes shadow[upd_id] only.
REQ-014 SHALL copy all shadow sets to active sets in the cycle h_ctr==H_TOTAL-1 and v_ctr==V_TOTAL-1 (commit); frame_start SHALL pulse in the following cycle.
REQ-015 SHALL drive upd_ready low only during the commit cycle; an update held valid across commit SHALL be accepted the next cycle and apply to the next frame.
REQ-016 SHALL ignore updates with upd_id >= N_SPR (accepted, no write).
REQ-017 SHALL flag a hit for channel i when enabled and x in [sx, sx+w) and y in [sy, sy+h), with sums at COORD_W+1 bits (no wrap); w==0 or h==0 SHALL never hit.
REQ-018 SHALL output colour of lowest-index hitting channel; no hit gives background; inactive region SHALL give 0,0,0 and blank_n=0.
REQ-019 SHALL have 2-cycle pipeline: hit compare stage, priority/colour stage; h_sync, v_sync, blank_n SHALL be delayed 2 cycles to stay aligned with RGB.

Reset
REQ-020 SHALL on reset clear counters, all shadow and active sets (disabled, zero), RGB=0, h_sync=v_sync=1, blank_n=0, frame_start=0, upd_ready=1.
REQ-021 SHALL on reset mid-frame discard pipeline contents and restart at h_ctr=v_ctr=0 the next cycle.

Configuration
REQ-022 SHALL, with VGA_TEST_PATTERN_EN defined, use as background 8 vertical colour bars of width H_ACT/8 (white, yellow, cyan, green, magenta, red, blue, black); without it background SHALL be black.

Structure
REQ-023 SHALL place default timing constants, rgb_t (24-bit struct) and sprite_t (x,y,w,h,en,rgb) in package vga_pkg.
REQ-024 SHALL implement counters and raw sync/active decode in sub-module vga_timing_gen.

Verification
REQ-025 Default params, free-run 2 frames -> h_sync period 800 clk, low 96; v_sync period 525 lines, low 2; frame_start every 420000 clk.
REQ-026 Write ch0 x=100,y=0,w=50,h=22,rgb=00FF00 mid-frame -> no change this frame; next frame pixels (100..149, 0..21) green, pixel 150 black.
REQ-027 ch0 and ch1 overlap, ch1 red, ch0 blue -> overlap blue; ch1-only area red.
REQ-028 upd_valid held across commit cycle -> upd_ready low exactly 1 cycle, update lands in following frame.
REQ-029 Sprite x=630,w=50 -> pixels 630..639 coloured, no wrap at x 0..39; w=0 -> nothing drawn.
REQ-030 Reset asserted at line 200 -> outputs at reset values, counters 0, sprites disabled; with VGA_TEST_PATTERN_EN pixel x=0 white, x=639 black.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults, colour/sprite types and the colour-bar palette for the VGA sprite engine.
// Sprite coordinates are stored at SPR_COORD_W bits; the engine supports COORD_W up to that width.
package vga_pkg;

    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_H_ACT  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;
    localparam int DEF_V_ACT  = 480;
    localparam int DEF_V_FP   = 10;

    localparam int SPR_COORD_W = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic [SPR_COORD_W-1:0] x;
        logic [SPR_COORD_W-1:0] y;
        logic [SPR_COORD_W-1:0] w;
        logic [SPR_COORD_W-1:0] h;
        logic                   en;
        rgb_t                   rgb;
    } sprite_t;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
            3'd1:    c = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
            3'd2:    c = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
            3'd3:    c = '{r: 8'h00, g: 8'hFF, b: 8'h00};
            3'd4:    c = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
            3'd5:    c = '{r: 8'hFF, g: 8'h00, b: 8'h00};
            3'd6:    c = '{r: 8'h00, g: 8'h00, b: 8'hFF};
            default: c = '{r: 8'h00, g: 8'h00, b: 8'h00};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters with raw (undelayed) sync, active-area and pixel-coordinate decode.
// commit marks the last pixel clock of the frame.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BP    = DEF_H_BP,
    parameter int H_ACT   = DEF_H_ACT,
    parameter int H_FP    = DEF_H_FP,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BP    = DEF_V_BP,
    parameter int V_ACT   = DEF_V_ACT,
    parameter int V_FP    = DEF_V_FP,
    parameter int COORD_W = 11
) (
    input  logic               clk,
    input  logic               reset,
    output logic               hs_n,
    output logic               vs_n,
    output logic               active,
    output logic               commit,
    output logic [COORD_W-1:0] px,
    output logic [COORD_W-1:0] py
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int H_OFF   = H_SYNC + H_BP;
    localparam int V_OFF   = V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_ctr;
    logic [VW-1:0] v_ctr;

    always_ff @(posedge clk) begin
        if (reset) begin
            h_ctr <= '0;
            v_ctr <= '0;
        end else if (h_ctr == H_LAST) begin
            h_ctr <= '0;
            v_ctr <= (v_ctr == V_LAST) ? '0 : v_ctr + 1'b1;
        end else begin
            h_ctr <= h_ctr + 1'b1;
        end
    end

    always_comb begin
        hs_n   = int'(h_ctr) >= H_SYNC;
        vs_n   = int'(v_ctr) >= V_SYNC;
        active = (int'(h_ctr) >= H_OFF) && (int'(h_ctr) < H_OFF + H_ACT) &&
                 (int'(v_ctr) >= V_OFF) && (int'(v_ctr) < V_OFF + V_ACT);
        commit = (h_ctr == H_LAST) && (v_ctr == V_LAST);
        px     = COORD_W'(int'(h_ctr) - H_OFF);
        py     = COORD_W'(int'(v_ctr) - V_OFF);
    end

endmodule

// File: rtl/vga_sprite_engine.sv
// VGA timing plus N_SPR double-buffered rectangular sprites composited over a background, 2-cycle pixel pipeline.
// Define VGA_TEST_PATTERN_EN for an 8-bar colour background instead of black.
module vga_sprite_engine
    import vga_pkg::*;
#(
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BP    = DEF_H_BP,
    parameter int H_ACT   = DEF_H_ACT,
    parameter int H_FP    = DEF_H_FP,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BP    = DEF_V_BP,
    parameter int V_ACT   = DEF_V_ACT,
    parameter int V_FP    = DEF_V_FP,
    parameter int N_SPR   = 4,
    parameter int COORD_W = 11,
    localparam int ID_W   = (N_SPR > 1) ? $clog2(N_SPR) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [ID_W-1:0]    upd_id,
    input  logic [COORD_W-1:0] upd_x,
    input  logic [COORD_W-1:0] upd_y,
    input  logic [COORD_W-1:0] upd_w,
    input  logic [COORD_W-1:0] upd_h,
    input  logic               upd_en,
    input  logic [23:0]        upd_rgb,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue,
    output logic               h_sync,
    output logic               v_sync,
    output logic               blank_n,
    output logic               sync_n,
    output logic               frame_start
);

    localparam int CW = SPR_COORD_W;

    logic               hs_n, vs_n, active, commit;
    logic [COORD_W-1:0] px, py;

    vga_timing_gen #(
        .H_SYNC (H_SYNC), .H_BP (H_BP), .H_ACT (H_ACT), .H_FP (H_FP),
        .V_SYNC (V_SYNC), .V_BP (V_BP), .V_ACT (V_ACT), .V_FP (V_FP),
        .COORD_W(COORD_W)
    ) u_timing (
        .clk   (clk),
        .reset (reset),
        .hs_n  (hs_n),
        .vs_n  (vs_n),
        .active(active),
        .commit(commit),
        .px    (px),
        .py    (py)
    );

    // Handshake: an update transfers on any clock where upd_valid && upd_ready;
    // ready drops only on the commit clock, so a held request lands one clock later.
    assign upd_ready = reset || !commit;
    assign sync_n    = 1'b0;

    sprite_t shadow_q [N_SPR];
    sprite_t active_q [N_SPR];
    sprite_t upd_spr;

    always_comb begin
        upd_spr     = '0;
        upd_spr.x   = CW'(upd_x);
        upd_spr.y   = CW'(upd_y);
        upd_spr.w   = CW'(upd_w);
        upd_spr.h   = CW'(upd_h);
        upd_spr.en  = upd_en;
        upd_spr.rgb = upd_rgb;
    end

    // Out-of-range ids match no channel, so they are accepted and dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SPR; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SPR; i++) begin
                if (commit)
                    active_q[i] <= shadow_q[i];
                if (upd_valid && upd_ready && int'(upd_id) == i)
                    shadow_q[i] <= upd_spr;
            end
        end
    end

    logic [N_SPR-1:0] hit_c;
    logic [CW:0]      px_e, py_e;

    // One extra bit on x+w / y+h so a sprite running past the coordinate range never wraps.
    always_comb begin
        hit_c = '0;
        px_e  = (CW + 1)'(px);
        py_e  = (CW + 1)'(py);
        for (int i = 0; i < N_SPR; i++) begin
            hit_c[i] = active_q[i].en &&
                       (px_e >= {1'b0, active_q[i].x}) &&
                       (px_e <  ({1'b0, active_q[i].x} + {1'b0, active_q[i].w})) &&
                       (py_e >= {1'b0, active_q[i].y}) &&
                       (py_e <  ({1'b0, active_q[i].y} + {1'b0, active_q[i].h}));
        end
    end

    rgb_t bg_c;
`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACT / 8;
    logic [2:0] bar_idx;
    always_comb begin
        bar_idx = 3'd7;
        if (int'(px) / BAR_W < 8)
            bar_idx = 3'(int'(px) / BAR_W);
        bg_c = bar_colour(bar_idx);
    end
`else
    assign bg_c = '0;
`endif

    logic [N_SPR-1:0] s1_hit;
    logic             s1_act, s1_hs, s1_vs;
    rgb_t             s1_bg;
    rgb_t             pix_c;

    // Lowest-index channel wins, so scan from the top down and let later writes override.
    always_comb begin
        pix_c = s1_bg;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (s1_hit[i])
                pix_c = active_q[i].rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hit      <= '0;
            s1_act      <= 1'b0;
            s1_hs       <= 1'b1;
            s1_vs       <= 1'b1;
            s1_bg       <= '0;
            red         <= 8'd0;
            green       <= 8'd0;
            blue        <= 8'd0;
            h_sync      <= 1'b1;
            v_sync      <= 1'b1;
            blank_n     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            s1_hit      <= hit_c;
            s1_act      <= active;
            s1_hs       <= hs_n;
            s1_vs       <= vs_n;
            s1_bg       <= bg_c;
            red         <= s1_act ? pix_c.r : 8'd0;
            green       <= s1_act ? pix_c.g : 8'd0;
            blue        <= s1_act ? pix_c.b : 8'd0;
            h_sync      <= s1_hs;
            v_sync      <= s1_vs;
            blank_n     <= s1_act;
            frame_start <= commit;
        end
    end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine on a shrunken raster: per-cycle reference-model compare plus a probe-pixel vector table.
// Honours VGA_TEST_PATTERN_EN for the expected background.
module tb_vga_sprite_engine;

    localparam int H_SYNC = 4, H_BP = 3, H_ACT = 64, H_FP = 5;
    localparam int V_SYNC = 2, V_BP = 3, V_ACT = 20, V_FP = 2;
    localparam int N_SPR  = 3, COORD_W = 11;
    localparam int HT     = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int VT     = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int FRAME  = HT * VT;
    localparam int HOFF   = H_SYNC + H_BP;
    localparam int VOFF   = V_SYNC + V_BP;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               upd_valid = 1'b0;
    logic               upd_ready;
    logic [1:0]         upd_id = '0;
    logic [COORD_W-1:0] upd_x = '0, upd_y = '0, upd_w = '0, upd_h = '0;
    logic               upd_en = 1'b0;
    logic [23:0]        upd_rgb = '0;
    logic [7:0]         red, green, blue;
    logic               h_sync, v_sync, blank_n, sync_n, frame_start;

    always #5 clk = ~clk;

    vga_sprite_engine #(
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
        .N_SPR(N_SPR), .COORD_W(COORD_W)
    ) dut (
        .clk(clk), .reset(reset),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_id(upd_id),
        .upd_x(upd_x), .upd_y(upd_y), .upd_w(upd_w), .upd_h(upd_h),
        .upd_en(upd_en), .upd_rgb(upd_rgb),
        .red(red), .green(green), .blue(blue),
        .h_sync(h_sync), .v_sync(v_sync), .blank_n(blank_n), .sync_n(sync_n),
        .frame_start(frame_start)
    );

    typedef struct {
        int          x, y, w, h;
        bit          en;
        logic [23:0] rgb;
    } spr_m_t;

    typedef struct {
        bit          do_upd;
        int          id, x, y, w, h;
        bit          en;
        logic [23:0] rgb;
        int          px, py;
        bit          exp_bg;
        logic [23:0] exp_rgb;
    } vec_t;

    spr_m_t      m_shadow [N_SPR];
    spr_m_t      m_active [N_SPR];
    logic [26:0] exp_q[$];
    vec_t        vecs [12];

    int          n_tests = 0, n_fail = 0;
    int          c = 0, last_fs = -1;
    bit          fs_exp = 0, last_acc = 0, saw_fs = 0;
    bit          probe_on = 0, probe_done = 0;
    int          probe_h = 0, probe_v = 0;
    logic [23:0] probe_exp = '0;
    string       probe_name = "";

    localparam logic [26:0] RESET_OUT = {24'h0, 1'b1, 1'b1, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, c);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d, expected event", name, c);
    endtask

    function automatic logic [23:0] bg_col(input int x);
        logic [23:0] bars [8];
        int b;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        b = x / (H_ACT / 8);
        if (b > 7) b = 7;
`ifdef VGA_TEST_PATTERN_EN
        return bars[b];
`else
        return (b >= 0) ? 24'h0 : bars[0];
`endif
    endfunction

    // Expected {rgb, h_sync, v_sync, blank_n} for a raster position, from the sprite rules.
    function automatic logic [26:0] model_pix(input int h, input int v);
        bit          hs, vs, act, found;
        int          x, y;
        logic [23:0] col;
        hs  = h >= H_SYNC;
        vs  = v >= V_SYNC;
        act = h >= HOFF && h < HOFF + H_ACT && v >= VOFF && v < VOFF + V_ACT;
        col = 24'h0;
        if (act) begin
            x = h - HOFF;
            y = v - VOFF;
            col = bg_col(x);
            found = 0;
            for (int i = 0; i < N_SPR; i++) begin
                if (!found && m_active[i].en &&
                    x >= m_active[i].x && x < m_active[i].x + m_active[i].w &&
                    y >= m_active[i].y && y < m_active[i].y + m_active[i].h) begin
                    col = m_active[i].rgb;
                    found = 1;
                end
            end
        end
        return {col, hs, vs, act};
    endfunction

    // Called at a falling edge with inputs for cycle c already driven; advances one clock.
    task automatic cycle();
        logic [26:0] e;
        int          h, v, ph, pv;
        bit          cm;
        h  = c % HT;
        v  = (c / HT) % VT;
        cm = (h == HT - 1) && (v == VT - 1);
        e  = exp_q.pop_front();
        check("pixel", {5'b0, red, green, blue, h_sync, v_sync, blank_n}, {5'b0, e});
        check("upd_ready", {31'b0, upd_ready}, {31'b0, !cm});
        check("frame_start", {31'b0, frame_start}, {31'b0, fs_exp});
        check("sync_n", {31'b0, sync_n}, 32'd0);
        if (frame_start === 1'b1) begin
            saw_fs = 1;
            if (last_fs >= 0)
                check("frame_period", c - last_fs, FRAME);
            last_fs = c;
        end
        if (probe_on && c >= 2) begin
            ph = (c - 2) % HT;
            pv = ((c - 2) / HT) % VT;
            if (ph == probe_h && pv == probe_v) begin
                check(probe_name, {8'h0, red, green, blue}, {8'h0, probe_exp});
                probe_done = 1;
                probe_on   = 0;
            end
        end
        exp_q.push_back(model_pix(h, v));
        last_acc = upd_valid && !cm;
        if (cm)
            for (int i = 0; i < N_SPR; i++) m_active[i] = m_shadow[i];
        if (last_acc && upd_id < N_SPR)
            m_shadow[upd_id] = '{x: int'(upd_x), y: int'(upd_y), w: int'(upd_w), h: int'(upd_h),
                                 en: upd_en, rgb: upd_rgb};
        fs_exp = cm;
        @(posedge clk);
        @(negedge clk);
        c++;
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        upd_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_rgb", {8'h0, red, green, blue}, 32'h0);
            check("rst_sync", {30'b0, h_sync, v_sync}, 32'd3);
            check("rst_blank_n", {31'b0, blank_n}, 32'd0);
            check("rst_frame_start", {31'b0, frame_start}, 32'd0);
            check("rst_upd_ready", {31'b0, upd_ready}, 32'd1);
        end
        reset = 1'b0;
        for (int i = 0; i < N_SPR; i++) begin
            m_shadow[i] = '{x: 0, y: 0, w: 0, h: 0, en: 0, rgb: 24'h0};
            m_active[i] = m_shadow[i];
        end
        exp_q.delete();
        exp_q.push_back(RESET_OUT);
        exp_q.push_back(RESET_OUT);
        c = 0; last_fs = -1; fs_exp = 0; probe_on = 0;
    endtask

    task automatic write_spr(input int id, input int x, input int y, input int w, input int h,
                             input bit en, input logic [23:0] rgb, output int waits);
        upd_id = 2'(id); upd_x = 11'(x); upd_y = 11'(y); upd_w = 11'(w); upd_h = 11'(h);
        upd_en = en; upd_rgb = rgb; upd_valid = 1'b1;
        waits = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (last_acc) break;
            waits++;
        end
        if (!last_acc) timeout("upd_accept");
        upd_valid = 1'b0;
    endtask

    task automatic wait_frame_start();
        saw_fs = 0;
        for (int k = 0; k < 2 * FRAME && !saw_fs; k++) cycle();
        if (!saw_fs) timeout("frame_start_wait");
    endtask

    task automatic run_probe(input int x, input int y, input logic [23:0] exp_rgb, input string name);
        probe_h = x + HOFF; probe_v = y + VOFF; probe_exp = exp_rgb; probe_name = name;
        probe_done = 0; probe_on = 1;
        for (int k = 0; k < FRAME + 4 && !probe_done; k++) cycle();
        if (!probe_done) begin
            probe_on = 0;
            timeout(name);
        end
    endtask

    initial begin
        int waits;
        int gap;
        //        upd id  x     y   w   h   en rgb          px  py  bg exp
        vecs[0]  = '{1, 0, 10,   0,  5,  4,  1, 24'h00FF00, 10,  0, 0, 24'h00FF00};
        vecs[1]  = '{0, 0, 0,    0,  0,  0,  0, 24'h0,      14,  3, 0, 24'h00FF00};
        vecs[2]  = '{0, 0, 0,    0,  0,  0,  0, 24'h0,      15,  0, 1, 24'h0};
        vecs[3]  = '{0, 0, 0,    0,  0,  0,  0, 24'h0,      10,  4, 1, 24'h0};
        vecs[4]  = '{1, 1, 12,   2, 10,  5,  1, 24'hFF0000, 13,  3, 0, 24'h00FF00};
        vecs[5]  = '{0, 0, 0,    0,  0,  0,  0, 24'h0,      16,  3, 0, 24'hFF0000};
        vecs[6]  = '{1, 0, 10,   0,  5,  4,  1, 24'h0000FF, 13,  3, 0, 24'h0000FF};
        vecs[7]  = '{1, 2, 60,  10, 20,  2,  1, 24'hFFFFFF, 63, 11, 0, 24'hFFFFFF};
        vecs[8]  = '{0, 0, 0,    0,  0,  0,  0, 24'h0,       1, 11, 1, 24'h0};
        vecs[9]  = '{1, 1, 12,   2,  0,  5,  1, 24'hFF0000, 16,  3, 1, 24'h0};
        vecs[10] = '{1, 3, 0,    0, 64, 20,  1, 24'h123456, 30, 15, 1, 24'h0};
        vecs[11] = '{1, 0, 10,   0,  5,  4,  0, 24'h0000FF, 10,  0, 1, 24'h0};

        do_reset(3);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_upd) begin
                write_spr(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h,
                          vecs[i].en, vecs[i].rgb, waits);
                wait_frame_start();
            end
            run_probe(vecs[i].px, vecs[i].py,
                      vecs[i].exp_bg ? bg_col(vecs[i].px) : vecs[i].exp_rgb,
                      $sformatf("vec%0d", i));
        end

        // Request presented on the commit clock: stalled exactly once, visible only a frame later.
        for (int k = 0; k < FRAME && (c % FRAME) != FRAME - 1; k++) cycle();
        write_spr(1, 0, 0, 4, 4, 1, 24'h00FFFF, waits);
        check("commit_stall_cycles", waits, 1);
        run_probe(1, 1, bg_col(1), "commit_same_frame");
        wait_frame_start();
        run_probe(1, 1, 24'h00FFFF, "commit_next_frame");

        repeat (25) begin
            gap = $urandom_range(0, 200);
            repeat (gap) cycle();
            write_spr($urandom_range(0, 3), $urandom_range(0, 70), $urandom_range(0, 24),
                      $urandom_range(0, 20), $urandom_range(0, 10), 1'($urandom_range(0, 1)),
                      24'($urandom), waits);
        end
        repeat (2 * FRAME + 4) cycle();

        // Reset in the middle of the active area.
        for (int k = 0; k < FRAME && ((c / HT) % VT) != VOFF + 10; k++) cycle();
        do_reset(2);
        repeat (2 * FRAME + 4) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
